// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller command port between NUM_REQ masters. Port 0 (video DMA)
// has capped fixed priority; the other ports rotate round-robin. One transaction in flight.
module sdram_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 32,
  parameter int HP_MAX  = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                        clk,
  input  logic                        reset_ni,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ-1:0]          req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_wmask_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic [NUM_REQ-1:0]          rsp_valid_o,
  output logic [DATA_W-1:0]           rsp_rdata_o,
  output logic                        mem_valid_o,
  input  logic                        mem_ready_i,
  output logic                        mem_we_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  output logic [DATA_W/8-1:0]         mem_wmask_o,
  input  logic                        mem_rvalid_i,
  input  logic [DATA_W-1:0]           mem_rdata_i,
  output logic                        busy_o,
  output logic                        err_o
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int HP_W   = $clog2(HP_MAX + 1);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [HP_W-1:0]    hp_count_reg, hp_count_next;
  logic [TMR_W-1:0]   timer_reg, timer_next;
  logic [IDX_W-1:0]   gnt_idx_reg;
  logic               mem_we_reg;
  logic [ADDR_W-1:0]  mem_addr_reg;
  logic [DATA_W-1:0]  mem_wdata_reg;
  logic [MASK_W-1:0]  mem_wmask_reg;
  logic [NUM_REQ-1:0] rsp_valid_reg;
  logic [DATA_W-1:0]  rsp_rdata_reg;
  logic               err_reg;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];
  logic [MASK_W-1:0]  wmask_arr [NUM_REQ];
  logic [IDX_W-1:0]   cand_idx  [NUM_REQ-1];
  logic [NUM_REQ-2:0] cand_valid;

  logic               others;
  logic               any_req;
  logic               p0_win;
  logic               rr_found;
  logic [IDX_W-1:0]   rr_idx;
  logic [IDX_W-1:0]   gnt_idx;
  logic               accept;
  logic               rsp_fire;
  logic               rsp_timeout;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr_i[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = req_wdata_i[gi*DATA_W +: DATA_W];
    assign wmask_arr[gi] = req_wmask_i[gi*MASK_W +: MASK_W];
  end

  // Candidate k is port rr_ptr+k, wrapped inside 1..NUM_REQ-1 (port 0 never rotates).
  for (gi = 0; gi < NUM_REQ - 1; gi++) begin : g_cand
    logic [IDX_W:0] sum;
    assign sum = {1'b0, rr_ptr_reg} + (IDX_W+1)'(gi);
    assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ?
                          IDX_W'(sum - (IDX_W+1)'(NUM_REQ - 1)) : sum[IDX_W-1:0];
    assign cand_valid[gi] = req_valid_i[cand_idx[gi]];
  end

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 0; k < NUM_REQ - 1; k++) begin
      if (!rr_found && cand_valid[k]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx[k];
      end
    end
  end

  assign others  = |req_valid_i[NUM_REQ-1:1];
  assign any_req = |req_valid_i;
  assign p0_win  = req_valid_i[0] && (!others || (hp_count_reg < HP_W'(HP_MAX)));
  assign gnt_idx = p0_win ? '0 : rr_idx;

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    hp_count_next = hp_count_reg;
    timer_next    = timer_reg;
    accept        = 1'b0;
    rsp_fire      = 1'b0;
    rsp_timeout   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (any_req) begin
          accept     = 1'b1;
          state_next = S_ISSUE;
          if (p0_win) begin
            hp_count_next = others ? hp_count_reg + HP_W'(1) : '0;
          end else begin
            hp_count_next = '0;
            rr_ptr_next   = (rr_idx == IDX_W'(NUM_REQ - 1)) ? IDX_W'(1) : rr_idx + IDX_W'(1);
          end
        end
      end
      S_ISSUE: begin
        if (mem_ready_i) begin
          timer_next = '0;
          state_next = mem_we_reg ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        // Real data wins over a timeout that would expire in the same cycle.
        if (mem_rvalid_i) begin
          rsp_fire   = 1'b1;
          state_next = S_IDLE;
        end else if (timer_reg == TMR_W'(TIMEOUT - 1)) begin
          rsp_fire    = 1'b1;
          rsp_timeout = 1'b1;
          state_next  = S_IDLE;
        end else begin
          timer_next = timer_reg + TMR_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg     <= S_IDLE;
      rr_ptr_reg    <= IDX_W'(1);
      hp_count_reg  <= '0;
      timer_reg     <= '0;
      gnt_idx_reg   <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_wmask_reg <= '0;
      rsp_valid_reg <= '0;
      rsp_rdata_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      hp_count_reg  <= hp_count_next;
      timer_reg     <= timer_next;
      rsp_valid_reg <= rsp_fire ? onehot(gnt_idx_reg) : '0;
      if (accept) begin
        gnt_idx_reg   <= gnt_idx;
        mem_we_reg    <= req_we_i[gnt_idx];
        mem_addr_reg  <= addr_arr[gnt_idx];
        mem_wdata_reg <= wdata_arr[gnt_idx];
        mem_wmask_reg <= wmask_arr[gnt_idx];
      end
      if (rsp_fire) begin
        rsp_rdata_reg <= rsp_timeout ? '0 : mem_rdata_i;
      end
      if (rsp_timeout) begin
        err_reg <= 1'b1;
      end
    end
  end

  // Acceptance is combinational, so it is masked while reset is held.
  assign req_ready_o = (accept && reset_ni) ? onehot(gnt_idx) : '0;
  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_rdata_o = rsp_rdata_reg;
  assign mem_valid_o = (state_reg == S_ISSUE);
  assign mem_we_o    = mem_we_reg;
  assign mem_addr_o  = mem_addr_reg;
  assign mem_wdata_o = mem_wdata_reg;
  assign mem_wmask_o = mem_wmask_reg;
  assign busy_o      = (state_reg != S_IDLE);
  assign err_o       = err_reg;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios plus randomized traffic checked
// against a grant-rule model and a bench-side memory responder.
module tb_sdram_port_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 24;
  localparam int DATA_W  = 32;
  localparam int HP_MAX  = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic [2:0]  req_valid_i, req_we_i;
  logic [71:0] req_addr_i;
  logic [95:0] req_wdata_i;
  logic [11:0] req_wmask_i;
  logic [2:0]  req_ready_o, rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        mem_valid_o, mem_ready_i, mem_we_o;
  logic [23:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o, err_o;

  sdram_port_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HP_MAX(HP_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_ni(reset_ni),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_wmask_i(req_wmask_i), .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Per-port copy of the request currently presented.
  logic        m_we    [NUM_REQ];
  logic [23:0] m_addr  [NUM_REQ];
  logic [31:0] m_wdata [NUM_REQ];
  logic [3:0]  m_wmask [NUM_REQ];

  // Reference arbitration state.
  int m_rr;
  int m_hp;
  bit m_err;

  typedef struct {
    logic [2:0]  gnt;
    logic        valid_c1;
    logic        stable;
    logic        we;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [2:0]  rsp;
    logic [31:0] rdata;
    int          rsp_lat;
    logic        busy_after;
    bit          tmo;
  } obs_t;

  task automatic set_req(input int p, input logic v, input logic we, input logic [23:0] a,
                         input logic [31:0] d, input logic [3:0] m);
    req_valid_i[p] = v;
    req_we_i[p]    = we;
    req_addr_i[p*ADDR_W +: ADDR_W]   = a;
    req_wdata_i[p*DATA_W +: DATA_W]  = d;
    req_wmask_i[p*4 +: 4]            = m;
    m_we[p] = we; m_addr[p] = a; m_wdata[p] = d; m_wmask[p] = m;
  endtask

  task automatic rand_req(input int p);
    set_req(p, 1'b1, 1'($urandom_range(0, 1)), 24'($urandom), $urandom, 4'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_ni = 1'b0;
    req_valid_i = '0; mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    @(negedge clk);
    reset_ni = 1'b1;
    m_rr = 1; m_hp = 0; m_err = 1'b0;
  endtask

  // Grant rule: capped port-0 priority, else first valid port from the rotating pointer.
  task automatic model_grant(input logic [2:0] v, output int g);
    bit oth;
    oth = |v[NUM_REQ-1:1];
    g = -1;
    if (v[0] && (!oth || m_hp < HP_MAX)) begin
      g = 0;
      m_hp = oth ? m_hp + 1 : 0;
    end else begin
      for (int k = 0; k < NUM_REQ - 1; k++) begin
        int p = 1 + (m_rr - 1 + k) % (NUM_REQ - 1);
        if (g < 0 && v[p]) g = p;
      end
      m_hp = 0;
      m_rr = (g == NUM_REQ - 1) ? 1 : g + 1;
    end
  endtask

  // Plays master and controller for one transaction; rvalid_lat < 0 means never return data.
  task automatic do_txn(input int ready_lat, input int rvalid_lat, input logic [31:0] rdata,
                        input bit keep, output obs_t o);
    int n;
    o.gnt = '0; o.valid_c1 = 1'b0; o.stable = 1'b1; o.we = 1'b0; o.addr = '0;
    o.wdata = '0; o.wmask = '0; o.rsp = '0; o.rdata = '0; o.rsp_lat = -1;
    o.busy_after = 1'b1; o.tmo = 1'b0;
    #1;
    n = 0;
    while (req_ready_o == 3'b000 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    if (req_ready_o == 3'b000) begin
      o.tmo = 1'b1;
      return;
    end
    o.gnt = req_ready_o;
    @(negedge clk);
    if (!keep) req_valid_i = req_valid_i & ~o.gnt;
    for (int i = 0; i <= ready_lat; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready_i = (i == ready_lat);
      #1;
      if (i == 0) begin
        o.valid_c1 = mem_valid_o; o.we = mem_we_o; o.addr = mem_addr_o;
        o.wdata = mem_wdata_o; o.wmask = mem_wmask_o;
      end else if (mem_valid_o !== 1'b1 || mem_we_o !== o.we || mem_addr_o !== o.addr ||
                   mem_wdata_o !== o.wdata || mem_wmask_o !== o.wmask) begin
        o.stable = 1'b0;
      end
      if (rsp_valid_o != 3'b000) o.rsp = rsp_valid_o;
    end
    @(negedge clk);
    mem_ready_i = 1'b0;
    if (o.we) begin
      #1;
      o.busy_after = busy_o;
      if (rsp_valid_o != 3'b000) o.rsp = rsp_valid_o;
    end else begin
      for (int k = 0; k < TIMEOUT + 8; k++) begin
        if (k > 0) @(negedge clk);
        mem_rvalid_i = (k == rvalid_lat);
        mem_rdata_i  = (k == rvalid_lat) ? rdata : $urandom;
        #1;
        if (rsp_valid_o != 3'b000) begin
          o.rsp = rsp_valid_o; o.rdata = rsp_rdata_o; o.rsp_lat = k; o.busy_after = busy_o;
          break;
        end
      end
      mem_rvalid_i = 1'b0;
      if (o.rsp == 3'b000) o.tmo = 1'b1;
    end
    $display("txn gnt=%b we=%b addr=%h wdata=%h rsp=%b rdata=%h lat=%0d",
             o.gnt, o.we, o.addr, o.wdata, o.rsp, o.rdata, o.rsp_lat);
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    req_valid_i = 3'b111; req_we_i = '0; req_addr_i = '0; req_wdata_i = '0; req_wmask_i = '0;
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    @(negedge clk); #1;
    n_cmp++;
    if ({req_ready_o, rsp_valid_o, mem_valid_o, busy_o, err_o} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got ready=%b rsp=%b mvalid=%b busy=%b err=%b required all 0",
               req_ready_o, rsp_valid_o, mem_valid_o, busy_o, err_o);
    end
    n_cmp++;
    if ({mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o, rsp_rdata_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got addr=%h wdata=%h rdata=%h required 0",
               mem_addr_o, mem_wdata_o, rsp_rdata_o);
    end
    req_valid_i = '0;
  endtask

  task automatic test_single_read();
    obs_t o;
    do_reset();
    set_req(1, 1'b1, 1'b0, 24'h000100, 32'h0, 4'h0);
    do_txn(1, 2, 32'h12345678, 1'b0, o);
    n_cmp++;
    if (o.tmo !== 1'b0) begin n_fail++; $display("FAIL rd_tmo got=%b required=0", o.tmo); end
    n_cmp++;
    if (o.gnt !== 3'b010) begin n_fail++; $display("FAIL rd_gnt got=%b required=010", o.gnt); end
    n_cmp++;
    if (o.valid_c1 !== 1'b1 || o.we !== 1'b0 || o.addr !== 24'h000100) begin
      n_fail++;
      $display("FAIL rd_cmd got v=%b we=%b addr=%h required 1/0/000100", o.valid_c1, o.we, o.addr);
    end
    n_cmp++;
    if (o.stable !== 1'b1) begin n_fail++; $display("FAIL rd_stable got=%b required=1", o.stable); end
    n_cmp++;
    if (o.rsp !== 3'b010 || o.rdata !== 32'h12345678) begin
      n_fail++;
      $display("FAIL rd_rsp got=%b/%h required=010/12345678", o.rsp, o.rdata);
    end
    n_cmp++;
    if (o.rsp_lat !== 3) begin n_fail++; $display("FAIL rd_lat got=%0d required=3", o.rsp_lat); end
  endtask

  task automatic test_write();
    obs_t o;
    logic stray;
    do_reset();
    set_req(2, 1'b1, 1'b1, 24'h0000FF, 32'hCAFEF00D, 4'b0011);
    do_txn(1, 0, 32'h0, 1'b0, o);
    n_cmp++;
    if (o.gnt !== 3'b100) begin n_fail++; $display("FAIL wr_gnt got=%b required=100", o.gnt); end
    n_cmp++;
    if (o.we !== 1'b1 || o.addr !== 24'h0000FF || o.wdata !== 32'hCAFEF00D || o.wmask !== 4'b0011) begin
      n_fail++;
      $display("FAIL wr_cmd got we=%b addr=%h wdata=%h wmask=%b required 1/0000ff/cafef00d/0011",
               o.we, o.addr, o.wdata, o.wmask);
    end
    n_cmp++;
    if (o.busy_after !== 1'b0) begin n_fail++; $display("FAIL wr_busy got=%b required=0", o.busy_after); end
    stray = |o.rsp;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (rsp_valid_o != 3'b000) stray = 1'b1;
    end
    n_cmp++;
    if (stray !== 1'b0) begin n_fail++; $display("FAIL wr_no_rsp got=%b required=0", stray); end
  endtask

  task automatic test_round_robin();
    obs_t o;
    logic [2:0] exp_g;
    logic [31:0] d;
    do_reset();
    set_req(1, 1'b1, 1'b0, 24'h000010, 32'h0, 4'h0);
    set_req(2, 1'b1, 1'b0, 24'h000020, 32'h0, 4'h0);
    for (int t = 0; t < 6; t++) begin
      d = $urandom;
      do_txn($urandom_range(0, 1), $urandom_range(0, 2), d, 1'b1, o);
      exp_g = (t % 2 == 0) ? 3'b010 : 3'b100;
      n_cmp++;
      if (o.gnt !== exp_g || o.rsp !== exp_g || o.rdata !== d) begin
        n_fail++;
        $display("FAIL rr_order[%0d] got gnt=%b rsp=%b rdata=%h required %b/%b/%h",
                 t, o.gnt, o.rsp, o.rdata, exp_g, exp_g, d);
      end
    end
  endtask

  task automatic test_hp_cap();
    obs_t o;
    int exp4 [11];
    exp4 = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0};
    do_reset();
    for (int p = 0; p < NUM_REQ; p++) set_req(p, 1'b1, 1'b0, 24'(p * 16), 32'h0, 4'h0);
    for (int t = 0; t < 11; t++) begin
      do_txn(0, 0, $urandom, 1'b1, o);
      n_cmp++;
      if (o.gnt !== 3'(1 << exp4[t]) || o.rsp !== o.gnt) begin
        n_fail++;
        $display("FAIL hp_order[%0d] got gnt=%b rsp=%b required=%b", t, o.gnt, o.rsp, 3'(1 << exp4[t]));
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    logic late;
    do_reset();
    set_req(1, 1'b1, 1'b0, 24'h000200, 32'h0, 4'h0);
    do_txn(0, -1, 32'h0, 1'b0, o);
    n_cmp++;
    if (o.rsp !== 3'b010 || o.rdata !== 32'h0 || o.rsp_lat !== TIMEOUT) begin
      n_fail++;
      $display("FAIL to_rsp got rsp=%b rdata=%h lat=%0d required 010/0/%0d",
               o.rsp, o.rdata, o.rsp_lat, TIMEOUT);
    end
    n_cmp++;
    if (err_o !== 1'b1) begin n_fail++; $display("FAIL to_err got=%b required=1", err_o); end
    @(negedge clk);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    #1;
    late = |rsp_valid_o;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    #1;
    late = late | (|rsp_valid_o) | busy_o;
    n_cmp++;
    if (late !== 1'b0) begin n_fail++; $display("FAIL to_late_rvalid got=%b required=0", late); end
    set_req(2, 1'b1, 1'b0, 24'h000300, 32'h0, 4'h0);
    do_txn(1, 1, 32'hA5A55A5A, 1'b0, o);
    n_cmp++;
    if (o.gnt !== 3'b100 || o.rsp !== 3'b100 || o.rdata !== 32'hA5A55A5A) begin
      n_fail++;
      $display("FAIL to_next got gnt=%b rsp=%b rdata=%h required 100/100/a5a55a5a", o.gnt, o.rsp, o.rdata);
    end
    n_cmp++;
    if (err_o !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky got=%b required=1", err_o); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    do_reset();
    set_req(1, 1'b1, 1'b0, 24'h000100, 32'h0, 4'h0);
    #1;
    n_cmp++;
    if (req_ready_o !== 3'b010) begin n_fail++; $display("FAIL rm_gnt got=%b required=010", req_ready_o); end
    @(negedge clk);
    req_valid_i = '0; mem_ready_i = 1'b1;
    @(negedge clk);
    mem_ready_i = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL rm_busy_wait got=%b required=1", busy_o); end
    #1;
    reset_ni = 1'b0;
    #1;
    n_cmp++;
    if ({busy_o, mem_valid_o, rsp_valid_o, req_ready_o, err_o} !== 9'b0 || mem_addr_o !== 24'h0) begin
      n_fail++;
      $display("FAIL rm_async got busy=%b mvalid=%b rsp=%b addr=%h required all 0",
               busy_o, mem_valid_o, rsp_valid_o, mem_addr_o);
    end
    @(negedge clk);
    reset_ni = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55AA55AA;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (rsp_valid_o != 3'b000 || busy_o || err_o) seen = 1'b1;
      @(negedge clk);
      mem_rvalid_i = 1'b0;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL rm_no_rsp got=%b required=0", seen); end
  endtask

  task automatic test_random();
    obs_t o;
    int g, rl, vl, exp_lat;
    logic [31:0] d, exp_d;
    logic        ew;
    logic [23:0] ea;
    logic [31:0] ed;
    logic [3:0]  em;
    do_reset();
    for (int p = 0; p < NUM_REQ; p++) if ($urandom_range(0, 1) == 1) rand_req(p);
    for (int t = 0; t < 40; t++) begin
      if (req_valid_i == 3'b000) rand_req(int'($urandom_range(0, NUM_REQ - 1)));
      model_grant(req_valid_i, g);
      ew = m_we[g]; ea = m_addr[g]; ed = m_wdata[g]; em = m_wmask[g];
      rl = int'($urandom_range(0, 3));
      vl = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
      d  = $urandom;
      do_txn(rl, vl, d, 1'b0, o);
      n_cmp++;
      if (o.gnt !== 3'(1 << g)) begin
        n_fail++; $display("FAIL rnd_gnt[%0d] got=%b required=%b", t, o.gnt, 3'(1 << g));
      end
      n_cmp++;
      if (o.valid_c1 !== 1'b1 || o.stable !== 1'b1 || o.we !== ew || o.addr !== ea ||
          (ew && (o.wdata !== ed || o.wmask !== em))) begin
        n_fail++;
        $display("FAIL rnd_cmd[%0d] got v=%b st=%b we=%b addr=%h wd=%h wm=%b required 1/1/%b/%h/%h/%b",
                 t, o.valid_c1, o.stable, o.we, o.addr, o.wdata, o.wmask, ew, ea, ed, em);
      end
      if (ew) begin
        n_cmp++;
        if (o.rsp !== 3'b000 || o.busy_after !== 1'b0) begin
          n_fail++; $display("FAIL rnd_wr[%0d] got rsp=%b busy=%b required 000/0", t, o.rsp, o.busy_after);
        end
      end else begin
        exp_d   = (vl < 0) ? 32'h0 : d;
        exp_lat = (vl < 0) ? TIMEOUT : vl + 1;
        if (vl < 0) m_err = 1'b1;
        n_cmp++;
        if (o.rsp !== 3'(1 << g) || o.rdata !== exp_d || o.rsp_lat !== exp_lat) begin
          n_fail++;
          $display("FAIL rnd_rd[%0d] got rsp=%b rdata=%h lat=%0d required %b/%h/%0d",
                   t, o.rsp, o.rdata, o.rsp_lat, 3'(1 << g), exp_d, exp_lat);
        end
      end
      n_cmp++;
      if (err_o !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d] got=%b required=%b", t, err_o, m_err); end
      for (int p = 0; p < NUM_REQ; p++) begin
        if (!req_valid_i[p] && $urandom_range(0, 2) != 0) rand_req(p);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_hp_cap();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

endmodule
